branch_predict_unit: RTL
========================

Name: branch_predict_unit

Overview:
- Parametrised successor to the single-bit branch decision logic in the ID stage.
- Resolves beq/bne/unconditional branches in ID and predicts branch direction in IF using a direct-mapped table of 2-bit saturating counters.
- Flags mispredictions so the pipeline redirects and flushes one IF instruction.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
- DEPTH, 64: number of prediction table entries; must be a power of 2, minimum 2.
- IDX_W, 6: table index width; must equal log2(DEPTH).
- PC_W, 32: program counter width.
- CNT_W, 32: width of each statistics counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- if_pc  input  PC_W  PC of the instruction being fetched.
- pred_taken  output  1  prediction for if_pc; combinational.
- id_valid  input  1  ID holds a valid instruction.
- id_stall  input  1  hazard unit is stalling ID (e.g. slt then beq on the same register).
- id_pc  input  PC_W  PC of the instruction in ID.
- id_branch  input  2  branch type: 00 none, 01 beq, 10 bne, 11 unconditional.
- id_zero  input  1  ID register-equality result (1 = operands equal).
- id_pred_taken  input  1  prediction carried down the pipeline with the instruction.
- PCSrc  output  1  actual branch outcome; combinational.
- mispredict  output  1  actual outcome differs from id_pred_taken; combinational.
- redirect_target  output  1  mispredict and branch taken; fetch the branch target.
- redirect_seq  output  1  mispredict and branch not taken; fetch id_pc+4.
- branch_cnt  output  CNT_W  number of resolved branches.
- mispred_cnt  output  CNT_W  number of resolved mispredictions.

Behaviour:
- Table index is pc[IDX_W+1:2]; low 2 PC bits are ignored; no tags, so aliasing is allowed.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- pred_taken = table[if_pc index][1].
- resolve = id_valid & ~id_stall & (id_branch != 00).
- Actual outcome (PCSrc):
  - 01: id_zero.
  - 10: ~id_zero.
  - 11: 1.
  - 00: 0.
  - PCSrc is forced to 0 when resolve = 0.
- mispredict = resolve & (PCSrc != id_pred_taken).
- redirect_target = mispredict & PCSrc.
- redirect_seq = mispredict & ~PCSrc.
- At most one redirect output is high at any time.
- Table update on the clock edge when resolve = 1:
  - Entry at id_pc index increments if PCSrc = 1, decrements otherwise.
  - Saturates at 11 and 00; no wrap-around.
- Read-during-write: if if_pc and id_pc map to the same entry in the update cycle, pred_taken returns the old value; the new value is visible from the next cycle.
- Stall: id_stall = 1 suppresses the table update, both statistics increments, and all ID outputs (PCSrc, mispredict, redirects = 0). Resolution completes in the first non-stalled cycle.
- Statistics, on the edge when resolve = 1:
  - branch_cnt += 1.
  - mispred_cnt += 1 only if mispredict = 1.
  - Both saturate at all-ones and never wrap.
- Reset (synchronous, takes priority over everything):
  - All table entries set to 01 (weak-NT), completed in one cycle.
  - branch_cnt = 0, mispred_cnt = 0.
- During the reset cycle, combinational outputs still follow their inputs; no state changes other than the reset values.
- Reset asserted mid-operation discards any pending update in that cycle.
- Latency: prediction and resolution are 0 cycles (combinational); state becomes visible 1 cycle after the update edge.

Test Plan:
- Reset then read: reset 1 cycle, then sweep if_pc over all DEPTH entries -> pred_taken = 0 everywhere; branch_cnt = mispred_cnt = 0.
- Training: beq at id_pc=0x40, id_zero=1, id_pred_taken=0, resolved 3 times:
  - Cycle 1: mispredict = 1, redirect_target = 1.
  - Entry goes 01 -> 10 -> 11 -> 11 (saturates).
  - pred_taken for if_pc=0x40 = 1 after the first update.
  - branch_cnt = 3, mispred_cnt = 3 (bench keeps id_pred_taken = 0 throughout).
- bne not-taken after training: id_branch=10, id_zero=1, id_pred_taken=1 -> PCSrc = 0, redirect_seq = 1; entry 11 -> 10.
- Stall and no-branch: id_stall=1 with id_branch=01 held for 4 cycles -> all outputs 0, table and counters unchanged. Also id_branch=00 -> no update.
- Read-during-write and aliasing: if_pc = id_pc = 0x80 in an update cycle -> pred_taken shows the old value that cycle, the new value the next. if_pc = 0x80 + 4*DEPTH reads the same entry.
- Saturation and reset: CNT_W=4 with 20 mispredicting branches -> both counters stop at 15. Assert reset mid-stream -> next cycle counters = 0 and all entries = 01.

Source files
------------

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - 2-bit saturating branch predictor with ID-stage resolution and statistics
module branch_predict_unit #(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6,
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic [PC_W-1:0]  id_pc,
  input  logic [1:0]       id_branch,
  input  logic             id_zero,
  input  logic             id_pred_taken,
  output logic             PCSrc,
  output logic             mispredict,
  output logic             redirect_target,
  output logic             redirect_seq,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic [1:0]       pht [DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] id_idx;
  logic             resolve;
  logic             outcome;
  logic             unused_pc;

  assign if_idx    = if_pc[IDX_W+1:2];
  assign id_idx    = id_pc[IDX_W+1:2];
  assign unused_pc = ^{if_pc, id_pc};

  // Table read is asynchronous, so a same-entry update this cycle is seen next cycle.
  assign pred_taken = pht[if_idx][1];

  assign resolve = id_valid & ~id_stall & (id_branch != 2'b00);

  always_comb begin
    outcome = 1'b0;
    case (id_branch)
      2'b01:   outcome = id_zero;
      2'b10:   outcome = ~id_zero;
      2'b11:   outcome = 1'b1;
      default: outcome = 1'b0;
    endcase
  end

  assign PCSrc           = resolve & outcome;
  assign mispredict      = resolve & (PCSrc != id_pred_taken);
  assign redirect_target = mispredict & PCSrc;
  assign redirect_seq    = mispredict & ~PCSrc;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pht[i] <= 2'b01;
      end
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (resolve) begin
      if (PCSrc) begin
        if (pht[id_idx] != 2'b11) pht[id_idx] <= pht[id_idx] + 2'b01;
      end else begin
        if (pht[id_idx] != 2'b00) pht[id_idx] <= pht[id_idx] - 2'b01;
      end
      if (branch_cnt != {CNT_W{1'b1}}) branch_cnt <= branch_cnt + CNT_W'(1);
      if (mispredict && (mispred_cnt != {CNT_W{1'b1}})) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule
